// File: rtl/qpsk_pkg.sv
// QPSK mapper shared types and tables: FSM state, differential phase
// increment per dibit, and quadrant-to-sign lookup.
package qpsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Gray-coded dibit -> quadrant increment (mod 4) for differential mode
  function automatic logic [1:0] gray_inc(input logic [1:0] d);
    logic [1:0] r;
    case (d)
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      2'b11:   r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Quadrant -> {i_neg, q_neg}; 0=(+,+) 1=(-,+) 2=(-,-) 3=(+,-)
  function automatic logic [1:0] quad_sign(input logic [1:0] qd);
    logic [1:0] r;
    case (qd)
      2'd0:    r = 2'b00;
      2'd1:    r = 2'b10;
      2'd2:    r = 2'b11;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/qpsk_symbol_mapper_if.sv
// Dibit valid/ready handshake between the serial-to-dibit splitter
// (master) and the QPSK symbol mapper (slave).
interface qpsk_symbol_mapper_if;
  logic [1:0] dibit_in;
  logic       dibit_valid;
  logic       dibit_ready;

  modport master (output dibit_in, output dibit_valid, input dibit_ready);
  modport slave  (input dibit_in, input dibit_valid, output dibit_ready);
endinterface

// File: rtl/qpsk_gray_map.sv
// Combinational sign selection for one QPSK symbol.
// QPSK_DIFF_ENC_EN defined: code is the quadrant (DQPSK).
// QPSK_DIFF_ENC_EN undefined: code is the dibit, absolute Gray map.
module qpsk_gray_map
  import qpsk_pkg::*;
(
  input  logic [1:0] code,
  output logic       i_neg,
  output logic       q_neg
);

`ifdef QPSK_DIFF_ENC_EN
  // quadrant lookup
  always_comb begin
    {i_neg, q_neg} = quad_sign(code);
  end
`else
  // bit 0 -> +AMP, bit 1 -> -AMP, independently per rail
  always_comb begin
    i_neg = code[1];
    q_neg = code[0];
  end
`endif

endmodule

// File: rtl/qpsk_symbol_mapper.sv
// QPSK symbol mapper: accepts dibits over valid/ready, maps to signed I/Q
// amplitudes and holds each symbol for SPS clocks.
// Optional macro QPSK_DIFF_ENC_EN selects differential (DQPSK) encoding.
module qpsk_symbol_mapper
  import qpsk_pkg::*;
#(
  parameter int SPS   = 4,
  parameter int AMP_W = 16,
  parameter int AMP   = 23170
) (
  input  logic                    clk,
  input  logic                    rst_n,
  qpsk_symbol_mapper_if.slave     dib,
  output logic signed [AMP_W-1:0] i_out,
  output logic signed [AMP_W-1:0] q_out,
  output logic                    sym_valid,
  output logic                    sym_strobe,
  output logic                    underrun
);

  localparam int                      CW      = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0]           CNT_MAX = CW'(SPS - 1);
  localparam logic signed [AMP_W-1:0] AMP_P   = AMP_W'(AMP);
  localparam logic signed [AMP_W-1:0] AMP_N   = -AMP_P;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pend_valid;
  logic [1:0]              pend_dibit;
  logic signed [AMP_W-1:0] i_d, q_d;
  logic                    strobe_d, underrun_d;
  logic                    load, accept;
  logic [1:0]              map_code;
  logic                    i_neg, q_neg;

  assign load = pend_valid && ((state_q == IDLE) || ((state_q == RUN) && (cnt_q == '0)));
  assign dib.dibit_ready = !pend_valid || load;
  assign accept = dib.dibit_valid && dib.dibit_ready;
  assign sym_valid = (state_q == RUN);

`ifdef QPSK_DIFF_ENC_EN
  logic [1:0] phase_q, phase_d;

  // Signs come from the quadrant being entered, so the map sees the next phase
  assign phase_d  = phase_q + gray_inc(pend_dibit);
  assign map_code = phase_d;

  // quadrant advances only when a symbol is loaded; survives idle periods
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    phase_q <= '0;
    else if (load) phase_q <= phase_d;
  end
`else
  assign map_code = pend_dibit;
`endif

  qpsk_gray_map u_map (
    .code  (map_code),
    .i_neg (i_neg),
    .q_neg (q_neg)
  );

  // one-entry pending register; a load frees it, an accept refills it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_dibit <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_dibit <= dib.dibit_in;
    end else if (load) begin
      pend_valid <= 1'b0;
    end
  end

  // next state, hold counter and symbol outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    i_d        = i_out;
    q_d        = q_out;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d  = RUN;
          cnt_d    = CNT_MAX;
          i_d      = i_neg ? AMP_N : AMP_P;
          q_d      = q_neg ? AMP_N : AMP_P;
          strobe_d = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (load) begin
          cnt_d    = CNT_MAX;
          i_d      = i_neg ? AMP_N : AMP_P;
          q_d      = q_neg ? AMP_N : AMP_P;
          strobe_d = 1'b1;
        end else begin
          state_d    = IDLE;
          i_d        = '0;
          q_d        = '0;
          underrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      i_out      <= '0;
      q_out      <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      i_out      <= i_d;
      q_out      <= q_d;
      sym_strobe <= strobe_d;
      underrun   <= underrun_d;
    end
  end

endmodule
